// File: rtl/adder_check_pkg.sv
// Shared types and helpers for the adder stimulus/response checker.
package adder_check_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 3;
  localparam int DEF_LATENCY = 2;

  // Sum of two operands truncated to 'bits' bits; the carry out is dropped.
  function automatic logic [31:0] exp_sum(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned bits);
    logic [31:0] mask;
    mask = (32'h1 << bits) - 32'h1;
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/adder_exp_pipe.sv
// Data+valid delay line that lines expected sums up with the datapath result.
module adder_exp_pipe #(
  parameter int DEPTH = 2,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  output logic [DW-1:0] head_data,
  output logic          head_vld
);

  logic [DW-1:0] data_q [DEPTH];
  logic          vld_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      data_q[0] <= in_data;
      vld_q[0]  <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign head_data = data_q[DEPTH-1];
  assign head_vld  = vld_q[DEPTH-1];

endmodule

// File: rtl/adder_stim_check.sv
// Exhaustive operand sweep and result checker for a registered adder datapath.
// Optional first-mismatch capture outputs: define ADDER_FIRST_ERR_CAPTURE_EN.
//
// state | meaning
// IDLE  | waiting for start, operand buses held at zero
// RUN   | driving one operand pair per cycle, expected sums enter the delay line
// DRAIN | last vector held, waiting LATENCY cycles for its result to be compared
// DONE  | sweep finished, done/pass/err_cnt held until start or rst
module adder_stim_check
  import adder_check_pkg::*;
#(
  parameter int width   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ERRW    = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [width:0]    Q,
  output logic [width:0]    DA,
  output logic [width:0]    DB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERRW-1:0]   err_cnt
`ifdef ADDER_FIRST_ERR_CAPTURE_EN
  ,
  output logic [2*width+1:0] first_err_idx,
  output logic [width:0]     first_err_q,
  output logic               first_err_vld
`endif
);

  localparam int BW = width + 1;
  localparam int IW = 2 * BW;
`ifdef ADDER_FIRST_ERR_CAPTURE_EN
  localparam int DW = IW + BW;
`else
  localparam int DW = BW;
`endif

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic            drv;
  logic [3:0]      drain_cnt;
  logic [BW-1:0]   exp_now;
  logic [DW-1:0]   pipe_in;
  logic [DW-1:0]   head_data;
  logic            head_vld;
  logic [BW-1:0]   head_exp;
  logic            mismatch;
  logic            sweep_go;
  logic            active;
  logic [ERRW-1:0] err_nxt;

  // The delay line samples the operand buses themselves, so it tracks what the
  // datapath actually saw rather than the index register.
  assign exp_now = BW'(exp_sum(32'(DA), 32'(DB), BW));
`ifdef ADDER_FIRST_ERR_CAPTURE_EN
  assign pipe_in = {DB, DA, exp_now};
`else
  assign pipe_in = exp_now;
`endif

  assign sweep_go = start && ((state == S_IDLE) || (state == S_DONE));
  assign active   = (state == S_RUN) || (state == S_DRAIN);
  assign idx_nxt  = idx + IW'(1);
  assign head_exp = head_data[BW-1:0];
  assign mismatch = active && head_vld && (Q != head_exp);

  always_comb begin
    err_nxt = err_cnt;
    if (mismatch && (err_cnt != {ERRW{1'b1}}))
      err_nxt = err_cnt + ERRW'(1);
  end

  adder_exp_pipe #(
    .DEPTH (LATENCY),
    .DW    (DW)
  ) u_exp_pipe (
    .clk       (CLK),
    .rst       (rst),
    .clr       (sweep_go),
    .in_data   (pipe_in),
    .in_vld    (drv),
    .head_data (head_data),
    .head_vld  (head_vld)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      DA        <= '0;
      DB        <= '0;
      drv       <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            idx     <= '0;
            DA      <= '0;
            DB      <= '0;
            drv     <= 1'b1;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        S_RUN: begin
          err_cnt <= err_nxt;
          idx     <= idx_nxt;
          if (idx == {IW{1'b1}}) begin
            state     <= S_DRAIN;
            drv       <= 1'b0;
            drain_cnt <= 4'(LATENCY - 1);
          end else begin
            DA <= idx_nxt[BW-1:0];
            DB <= idx_nxt[IW-1:BW];
          end
        end
        S_DRAIN: begin
          err_cnt <= err_nxt;
          if (drain_cnt == 4'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER_FIRST_ERR_CAPTURE_EN
  always_ff @(posedge CLK) begin
    if (rst || sweep_go) begin
      first_err_idx <= '0;
      first_err_q   <= '0;
      first_err_vld <= 1'b0;
    end else if (mismatch && !first_err_vld) begin
      first_err_idx <= head_data[DW-1:BW];
      first_err_q   <= Q;
      first_err_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/adder_stim_check.md
Name: adder_stim_check

Overview:
- Self-checking stimulus/response block for the registered two-operand adder datapath.
- Sits on the far side of that datapath's interface:
  - drives the DA/DB operand buses;
  - samples the Q result bus;
  - compares Q against a locally computed expected sum, delayed by the datapath latency.
- Sweeps every operand pair exhaustively, counts mismatches and reports pass/fail.
- Used as the on-chip checker in map/par regression designs.

Parameters:
- width, 3: MSB index of operand/result buses; buses are width+1 bits.
- LATENCY, 2: clocks from DA/DB drive to the matching Q; legal range 1..8.
- ERRW, 16: error counter width.

Ports:
- CLK  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- Q  input  width+1  result from the adder datapath.
- DA  output  width+1  operand A.
- DB  output  width+1  operand B.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid while done; 1 = zero mismatches.
- err_cnt  output  ERRW  mismatch count, saturating.

Behaviour:
- Reset: rst sampled on rising CLK only. All outputs are 0 on the cycle after rst. State goes to IDLE; vector index, delay line valid bits and err_cnt clear.
- rst asserted mid-sweep aborts immediately; no partial result is reported.
- Vector index idx: 2*(width+1) bits. DA = idx[width:0], DB = idx[2*width+1:width+1]. DA/DB are registered outputs.
- Expected value: (DA+DB) mod 2^(width+1); the carry is dropped, matching the datapath. It enters a LATENCY-deep shift register together with a valid bit.
- Compare: each cycle the delay-line head has valid=1, sample Q. If Q != expected, err_cnt increments, saturating at 2^ERRW-1.
- States:
  - IDLE: outputs DA=DB=0. start -> RUN; idx=0; err_cnt cleared.
  - RUN: drives vector idx each cycle and pushes expected with valid=1. idx increments every cycle. When idx = all-ones has been driven -> DRAIN. idx wraps to 0 but is unused.
  - DRAIN: holds DA/DB at the last vector and pushes valid=0. After exactly LATENCY cycles (last compare done) -> DONE.
  - DONE: done=1, pass=(err_cnt==0). Both hold until start or rst. start -> RUN with err_cnt and idx cleared; done drops the next cycle.
- start while busy is ignored. start coincident with rst: rst wins.
- Sweep length: 2^(2*(width+1)) drive cycles + LATENCY drain cycles. width=3 gives 256 + 2 = 258 cycles from start to done.
- The first compare happens LATENCY cycles after the first vector is driven. Q is never compared in IDLE or DONE.

Optional Feature:
- Macro: ADDER_FIRST_ERR_CAPTURE_EN.
- Defined:
  - Extra outputs first_err_idx (2*(width+1) bits), first_err_q (width+1 bits) and first_err_vld (1 bit).
  - On the first mismatch of a sweep, these capture the vector index and the Q value seen, then hold.
  - All three are cleared by rst and by start.
- Not defined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package adder_check_pkg holds:
  - state encoding typedef (IDLE, RUN, DRAIN, DONE);
  - default width/LATENCY constants;
  - function exp_sum(a,b) returning the truncated sum.
- Sub-module adder_exp_pipe: LATENCY-deep data+valid shift register with synchronous clear. It is instantiated once.

Test Plan:
- Golden loop: connect the adder datapath (latency 2), pulse start -> busy for 258 cycles, done=1, pass=1, err_cnt=0.
- Stuck-at fault: model Q bit0 forced 0 -> err_cnt=128 (half of 256 sums are odd), pass=0. With ADDER_FIRST_ERR_CAPTURE_EN: first_err_idx=1, first_err_q=0.
- Wrap/carry: idx=0xFF drives DA=15, DB=15 -> expected 14 (carry dropped). An ideal model returning 30 truncated to 4 bits gives no error.
- Latency mismatch: model with latency 3, LATENCY=2 -> err_cnt nonzero (255 expected), pass=0.
- Mid-sweep reset: rst at cycle 100 of RUN -> next cycle DA=DB=0, busy=0, err_cnt=0. A start 5 cycles later runs a full clean sweep, pass=1.
- Control edges:
  - start pulsed during RUN -> ignored, sweep length unchanged.
  - start in DONE -> new sweep; done low the next cycle.
  - start and rst together -> stays IDLE.
